// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter draining a TX FIFO; optional even parity via UART_TX_PARITY_EN
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic                 i_fifo_empty,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    output logic                 o_fifo_read,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int TW = $clog2(SB_TICKS > 16 ? SB_TICKS : 16);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] BIT_TICK_LAST  = TW'(15);
    localparam logic [TW-1:0] STOP_TICK_LAST = TW'(SB_TICKS - 1);
    localparam logic [BW-1:0] DATA_BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state and counter/shift updates; ticks only matter once the start bit is on the line
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!i_fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d  = i_fifo_data;
                tick_d   = '0;
                bit_d    = '0;
`ifdef UART_TX_PARITY_EN
                parity_d = ^i_fifo_data;
`endif
                state_d  = S_START;
            end
            S_START: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        tick_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == DATA_BIT_LAST) begin
                            bit_d = '0;
`ifdef UART_TX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        tick_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (i_tick) begin
                    if (tick_q == STOP_TICK_LAST) begin
                        tick_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: line level is decoded from the next state so the pin itself comes straight off a flop
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        o_fifo_read = (state_q == S_FETCH);
        o_busy      = (state_q != S_IDLE) && (state_q != S_FETCH);
        o_done      = (state_q == S_STOP) && i_tick && (tick_q == STOP_TICK_LAST);
    end

    assign o_tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a per-tick line model
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 32;
    localparam int PB = 1;
`else
    localparam int SB = 16;
    localparam int PB = 0;
`endif
    localparam int FRAME_TICKS = 16 * (1 + DB + PB) + SB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DB-1:0] fifo_data = '0;
    logic          fifo_read, tx, busy, done;

    uart_tx #(.DATA_BITS(DB), .SB_TICKS(SB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick       (tick),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_read  (fifo_read),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         tick_div = 4;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    bit         samp[$];
    bit         pop_pending = 0;
    bit         in_frame = 0;
    bit         gap_armed = 0;
    int         pops = 0, dones = 0, frames_started = 0, frames_done = 0;
    int         busy_low = 0, done_cyc = 0, gap_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic finish_frame();
        logic [7:0] e;
        logic [7:0] d;
        int         mism;
        int         k;
        bit         want;
        frames_done++;
        check("frame_has_byte", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        mism = 0;
        d = '0;
        for (int i = 0; i < FRAME_TICKS; i++) begin
            k = i / 16;
            if (k == 0) want = 1'b0;
            else if (k <= DB) want = e[k-1];
            else if (PB == 1 && k == DB + 1) want = ^e;
            else want = 1'b1;
            if (samp[i] != want) mism++;
        end
        for (int j = 0; j < DB; j++) d[j] = samp[16 * (j + 1) + 8];
        check("frame_byte", d, e);
        check("frame_shape", mism, 0);
        check("frame_busy", busy_low, 0);
        check("done_at_stop_end", done, 1);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", samp[16 * (DB + 1) + 8], ^e);
`endif
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(fifo_q.size() == 0 && exp_q.size() == 0 && !in_frame &&
                               !busy && !pop_pending && fifo_empty)) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", n < budget, 1);
        repeat (4) @(negedge clk);
    endtask

    // Baud tick generator and cycle counter
    initial begin : tickgen
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            n++;
            if (n >= tick_div) n = 0;
            tick = (n == 0);
        end
    end

    // FIFO model: read data appears the cycle after the pop request
    initial begin : fifo_model
        forever begin
            @(negedge clk);
            if (fifo_read) begin
                pops++;
                check("pop_nonempty", fifo_q.size() > 0, 1);
                if (fifo_q.size() > 0) pop_pending = 1;
            end
            @(posedge clk);
            #1;
            if (pop_pending) begin
                fifo_data = fifo_q.pop_front();
                exp_q.push_back(fifo_data);
                pop_pending = 0;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Line monitor: records the line level at every tick of a frame
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (done) dones++;
            if (rst) begin
                in_frame = 0;
                samp.delete();
                exp_q.delete();
                gap_armed = 0;
            end else begin
                if (!in_frame && tx == 1'b0) begin
                    in_frame = 1;
                    samp.delete();
                    busy_low = 0;
                    frames_started++;
                    if (gap_armed) begin
                        gap_checks++;
                        check("b2b_gap", cyc - done_cyc - 1, 3);
                    end
                    gap_armed = 0;
                end
                if (in_frame) begin
                    if (!busy) busy_low++;
                    if (tick) begin
                        samp.push_back(tx);
                        if (samp.size() == FRAME_TICKS) begin
                            finish_frame();
                            in_frame = 0;
                        end
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    gap_armed = !fifo_empty;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int p0, d0, f0, g0, low, n, nb;

        #1 rst = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_read", fifo_read, 0);
        check("rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        p0 = pops;
        low = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!tx) low++;
        end
        check("empty_pops", pops - p0, 0);
        check("empty_tx_low", low, 0);

        p0 = pops; d0 = dones; f0 = frames_done;
        push(8'hA5);
        wait_idle(4000);
        check("a5_pops", pops - p0, 1);
        check("a5_dones", dones - d0, 1);
        check("a5_frames", frames_done - f0, 1);

        p0 = pops; d0 = dones; g0 = gap_checks;
        push(8'h00);
        push(8'hFF);
        wait_idle(8000);
        check("b2b_pops", pops - p0, 2);
        check("b2b_dones", dones - d0, 2);
        check("b2b_gap_seen", gap_checks - g0, 1);

        p0 = pops; d0 = dones;
        push(8'h07);
        push(8'h03);
        wait_idle(8000);
        check("par_pops", pops - p0, 2);
        check("par_dones", dones - d0, 2);

        push(8'h0F);
        n = 0;
        while (n < 3000 && !(in_frame && samp.size() >= 72)) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit3", n < 3000, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = dones; f0 = frames_started; low = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!tx) low++;
        end
        check("post_rst_tx_low", low, 0);
        check("post_rst_frames", frames_started - f0, 0);
        check("post_rst_dones", dones - d0, 0);

        for (int r = 0; r < 6; r++) begin
            tick_div = $urandom_range(2, 6);
            nb = $urandom_range(1, 3);
            p0 = pops; d0 = dones;
            for (int k = 0; k < nb; k++) push(8'($urandom_range(0, 255)));
            wait_idle(20000);
            check("rand_pops", pops - p0, nb);
            check("rand_dones", dones - d0, nb);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
